// File: rtl/dbg_led_pkg.sv
// Shared types and constants for the debug activity LED block.
package dbg_led_pkg;

  localparam int unsigned EVT_CNT_W = 16;

  typedef enum logic [1:0] {
    MODE_PASS    = 2'd0,
    MODE_STRETCH = 2'd1,
    MODE_TOGGLE  = 2'd2,
    MODE_DIM     = 2'd3
  } led_mode_e;

  // Modes that drive the LED from the stretch counter.
  function automatic logic mode_uses_stretch(led_mode_e mode);
    return (mode == MODE_STRETCH) || (mode == MODE_DIM);
  endfunction

endpackage

// File: rtl/dbg_led_channel.sv
// One debug LED channel: input synchroniser, rising-edge activity detect, mode-dependent LED
// drive (pass/stretch/toggle/dim) and a saturating event counter.
module dbg_led_channel
  import dbg_led_pkg::*;
#(
  parameter int unsigned STRETCH_CYCLES = 8,
  parameter int unsigned CNT_W          = $clog2(STRETCH_CYCLES + 1),
  parameter bit          INV            = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 sig_i,
  input  logic [1:0]           mode_i,
  input  logic                 clear_i,
  input  logic                 pwm_lt_duty_i,
  output logic                 led_o,
  output logic                 event_o,
  output logic [EVT_CNT_W-1:0] event_cnt_o
);

  localparam logic [CNT_W-1:0] Reload = CNT_W'(STRETCH_CYCLES - 1);

  logic                 sync1_q, sync2_q;
  logic                 s, s_q;
  logic                 ev;
  logic                 mode_chg;
  led_mode_e            mode_d, mode_q;
  logic [CNT_W-1:0]     cnt_d, cnt_q;
  logic                 tgl_d, tgl_q;
  logic                 led_d, led_q;
  logic                 evt_q;
  logic [EVT_CNT_W-1:0] evt_cnt_d, evt_cnt_q;

  assign s        = sync2_q ^ INV;
  assign ev       = s & ~s_q;
  assign mode_d   = led_mode_e'(mode_i);
  assign mode_chg = (mode_d != mode_q);

  always_comb begin
    cnt_d = cnt_q;
    tgl_d = tgl_q;
    led_d = 1'b0;

    unique case (mode_q)
      MODE_PASS: led_d = s;
      MODE_STRETCH, MODE_DIM: begin
        if (ev) begin
          cnt_d = Reload;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
        if (ev || (cnt_q != '0)) begin
          led_d = 1'b1;
        end else begin
          led_d = (mode_q == MODE_DIM) & pwm_lt_duty_i;
        end
      end
      MODE_TOGGLE: tgl_d = tgl_q ^ ev;
    endcase

    // A mode switch restarts the channel state; the new mode takes over next cycle.
    if (mode_chg) begin
      cnt_d = '0;
      tgl_d = 1'b0;
    end

    if (mode_q == MODE_TOGGLE) begin
      led_d = tgl_d;
    end
  end

  always_comb begin
    evt_cnt_d = evt_cnt_q;
    if (clear_i) begin
      evt_cnt_d = '0;
    end else if (ev && (evt_cnt_q != '1)) begin
      evt_cnt_d = evt_cnt_q + 1'b1;
    end
  end

  // Synchroniser resets to the inactive level so inverted channels see no edge on release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= INV;
      sync2_q   <= INV;
      s_q       <= 1'b0;
      mode_q    <= MODE_PASS;
      cnt_q     <= '0;
      tgl_q     <= 1'b0;
      led_q     <= 1'b0;
      evt_q     <= 1'b0;
      evt_cnt_q <= '0;
    end else begin
      sync1_q   <= sig_i;
      sync2_q   <= sync1_q;
      s_q       <= s;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      tgl_q     <= tgl_d;
      led_q     <= led_d;
      evt_q     <= ev;
      evt_cnt_q <= evt_cnt_d;
    end
  end

  assign led_o       = led_q;
  assign event_o     = evt_q;
  assign event_cnt_o = evt_cnt_q;

  // Stretch counter is only meaningful in stretch-based modes.
  logic unused_stretch_chk;
  assign unused_stretch_chk = mode_uses_stretch(mode_q) & 1'b0;

endmodule

// File: rtl/dbg_activity_led.sv
// Debug activity LED driver: N_CH independent channels sharing one free-running PWM counter
// used for the DIM-mode idle glow.
module dbg_activity_led
  import dbg_led_pkg::*;
#(
  parameter int unsigned    N_CH           = 4,
  parameter int unsigned    STRETCH_CYCLES = 2 ** 20,
  parameter int unsigned    CNT_W          = $clog2(STRETCH_CYCLES + 1),
  parameter logic [N_CH-1:0] INV_MASK      = '0,
  parameter int unsigned    PWM_W          = 4,
  parameter int unsigned    DIM_DUTY       = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N_CH-1:0]           sig_i,
  input  logic [2*N_CH-1:0]         mode_i,
  input  logic                      clear_i,
  output logic [N_CH-1:0]           led_o,
  output logic [N_CH-1:0]           event_o,
  output logic [EVT_CNT_W*N_CH-1:0] event_cnt_o
);

  logic [PWM_W-1:0] pwm_d, pwm_q;
  logic             pwm_lt_duty;

  always_comb begin
    pwm_d = pwm_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  assign pwm_lt_duty = (32'(pwm_q) < DIM_DUTY);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    dbg_led_channel #(
      .STRETCH_CYCLES(STRETCH_CYCLES),
      .CNT_W         (CNT_W),
      .INV           (INV_MASK[i])
    ) u_chan (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .sig_i        (sig_i[i]),
      .mode_i       (mode_i[2*i +: 2]),
      .clear_i      (clear_i),
      .pwm_lt_duty_i(pwm_lt_duty),
      .led_o        (led_o[i]),
      .event_o      (event_o[i]),
      .event_cnt_o  (event_cnt_o[EVT_CNT_W*i +: EVT_CNT_W])
    );
  end

endmodule

// File: tb/tb_dbg_activity_led.sv
// Self-checking bench for dbg_activity_led: per-cycle scoreboard of stimulus and expected LED /
// event outputs, plus direct checks of the event counters.
module tb_dbg_activity_led;
  import dbg_led_pkg::*;

  localparam int unsigned N_CH     = 2;
  localparam int unsigned SC       = 8;
  localparam int unsigned PWM_W    = 2;
  localparam int unsigned DIM_DUTY = 1;
  localparam logic [1:0]  INV      = 2'b10;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [N_CH-1:0]           sig_i;
  logic [2*N_CH-1:0]         mode_i;
  logic                      clear_i;
  logic [N_CH-1:0]           led_o;
  logic [N_CH-1:0]           event_o;
  logic [EVT_CNT_W*N_CH-1:0] event_cnt_o;

  always #5 clk = ~clk;

  dbg_activity_led #(
    .N_CH          (N_CH),
    .STRETCH_CYCLES(SC),
    .INV_MASK      (INV),
    .PWM_W         (PWM_W),
    .DIM_DUTY      (DIM_DUTY)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .sig_i      (sig_i),
    .mode_i     (mode_i),
    .clear_i    (clear_i),
    .led_o      (led_o),
    .event_o    (event_o),
    .event_cnt_o(event_cnt_o)
  );

  typedef struct {
    logic [1:0] sig;
    logic [3:0] mode;
    logic [1:0] led;
    logic [1:0] led_chk;
    logic [1:0] evt;
    logic [1:0] evt_chk;
  } cyc_t;

  cyc_t  sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  string seg     = "reset";

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic void push(logic [1:0] sig, logic [3:0] mode, logic [1:0] led,
                               logic [1:0] lchk, logic [1:0] evt, logic [1:0] echk);
    cyc_t c;
    c.sig = sig; c.mode = mode; c.led = led; c.led_chk = lchk; c.evt = evt; c.evt_chk = echk;
    sb.push_back(c);
  endfunction

  // Expected DIM idle level after edge n (n counted from the first edge after reset release).
  function automatic logic pwm_led(int n);
    return ((n - 1) % (1 << PWM_W)) < DIM_DUTY;
  endfunction

  task automatic run_sb();
    cyc_t c;
    while (sb.size() > 0) begin
      c = sb.pop_front();
      sig_i  = c.sig;
      mode_i = c.mode;
      step();
      for (int ch = 0; ch < N_CH; ch++) begin
        if (c.led_chk[ch]) check_val($sformatf("%s_led%0d", seg, ch), 32'(led_o[ch]), 32'(c.led[ch]));
        if (c.evt_chk[ch]) check_val($sformatf("%s_evt%0d", seg, ch), 32'(event_o[ch]), 32'(c.evt[ch]));
      end
    end
  endtask

  function automatic logic [15:0] cnt(int ch);
    return event_cnt_o[16*ch +: 16];
  endfunction

  initial begin
    logic [3:0] m;
    int         base;
    rst_n   = 1'b0;
    sig_i   = 2'b10;
    clear_i = 1'b0;
    m       = {MODE_PASS, MODE_STRETCH};
    mode_i  = m;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_led", 32'(led_o), 32'h0);
    check_val("rst_evt", 32'(event_o), 32'h0);
    check_val("rst_cnt", event_cnt_o, 32'h0);
    rst_n = 1'b1;
    cyc   = 0;

    seg = "idle";
    for (int i = 1; i <= 6; i++) push(2'b10, m, 2'b00, 2'b11, 2'b00, 2'b11);
    run_sb();
    check_val("idle_cnt", event_cnt_o, 32'h0);

    seg = "stretch1";
    for (int i = 1; i <= 14; i++)
      push({1'b1, i == 1}, m, {1'b0, (i >= 3 && i <= 10)}, 2'b11, {1'b0, i == 3}, 2'b11);
    run_sb();
    check_val("stretch1_cnt0", 32'(cnt(0)), 32'd1);

    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    check_val("clear_cnt0", 32'(cnt(0)), 32'd0);

    seg = "stretch2";
    for (int i = 1; i <= 18; i++)
      push({1'b1, (i == 1 || i == 6)}, m, {1'b0, (i >= 3 && i <= 15)}, 2'b11,
           {1'b0, (i == 3 || i == 8)}, 2'b11);
    run_sb();
    check_val("stretch2_cnt0", 32'(cnt(0)), 32'd2);

    // Toggle with three pulses, then switch to PASS and watch it track the input.
    seg = "toggle";
    for (int i = 1; i <= 24; i++) begin
      logic l0;
      m  = (i < 12) ? {MODE_PASS, MODE_TOGGLE} : {MODE_PASS, MODE_PASS};
      l0 = (i >= 5 && i <= 7) || (i == 11) || (i >= 16 && i <= 18);
      push({1'b1, (i == 3 || i == 6 || i == 9 || (i >= 14 && i <= 16))}, m, {1'b0, l0},
           (i == 12) ? 2'b10 : 2'b11, {1'b0, (i == 5 || i == 8 || i == 11 || i == 16)}, 2'b11);
    end
    run_sb();

    seg = "tgl_clr";
    m = {MODE_PASS, MODE_TOGGLE};
    for (int i = 1; i <= 8; i++)
      push({1'b1, i == 3}, m, {1'b0, i >= 5}, 2'b11, {1'b0, i == 5}, 2'b11);
    run_sb();

    seg  = "dim";
    m    = {MODE_DIM, MODE_TOGGLE};
    base = cyc;
    for (int i = 1; i <= 27; i++) begin
      logic l1;
      l1 = (i >= 12 && i <= 19) ? 1'b1 : pwm_led(base + i);
      push({i != 10, 1'b0}, m, {l1, 1'b1}, (i == 1) ? 2'b01 : 2'b11, {i == 12, 1'b0}, 2'b11);
    end
    run_sb();
    check_val("dim_cnt1", 32'(cnt(1)), 32'd1);

    // Preload the counter near the top so saturation is reachable in a short run.
    mode_i = {MODE_DIM, MODE_PASS};
    repeat (3) step();
    force dut.g_ch[0].u_chan.evt_cnt_q = 16'hFFF0;
    #1;
    release dut.g_ch[0].u_chan.evt_cnt_q;
    for (int i = 0; i < 16; i++) begin
      sig_i[0] = (i % 2 == 0);
      step();
    end
    sig_i[0] = 1'b0;
    repeat (4) step();
    check_val("sat_pre_cnt0", 32'(cnt(0)), 32'hFFF8);
    for (int i = 0; i < 24; i++) begin
      sig_i[0] = (i % 2 == 0);
      step();
    end
    sig_i[0] = 1'b0;
    repeat (4) step();
    check_val("sat_cnt0", 32'(cnt(0)), 32'hFFFF);

    sig_i[0] = 1'b1;
    step();
    sig_i[0] = 1'b0;
    step();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    check_val("clr_ev_evt0", 32'(event_o[0]), 32'd1);
    check_val("clr_ev_cnt0", 32'(cnt(0)), 32'd0);
    step();
    check_val("clr_ev_cnt0_after", 32'(cnt(0)), 32'd0);

    mode_i = {MODE_DIM, MODE_STRETCH};
    repeat (2) step();
    sig_i[0] = 1'b1;
    step();
    sig_i[0] = 1'b0;
    repeat (4) step();
    check_val("arst_led_before", 32'(led_o[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_led_drop", 32'(led_o[0]), 32'd0);
    check_val("arst_cnt", event_cnt_o, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) step();
    check_val("arst_led_after", 32'(led_o[0]), 32'd0);
    sig_i[0] = 1'b1;
    step();
    sig_i[0] = 1'b0;
    repeat (3) step();
    check_val("arst_cnt_resume", 32'(cnt(0)), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
